tmds_channel_rd: RTL

//  Single HDMI TMDS lane encoder with integrated 8b/10b video coding and running-disparity tracking,

---
 rtl/tmds_channel_rd_if.sv | 34 +++
 rtl/tmds_channel_rd.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tmds_channel_rd_if.sv
// TMDS lane bus: mode/data inputs from the source, encoded symbol back.
// master drives mode/data, slave (encoder) drives tmds (+ disparity).
interface tmds_channel_rd_if;
  logic [7:0] video_data;
  logic [3:0] data_island_data;
  logic [1:0] control_data;
  logic [2:0] mode;
  logic [9:0] tmds;
`ifdef TMDS_DISP_MON_EN
  logic signed [5:0] disparity;

  modport master (
    output video_data, data_island_data,
    output control_data, mode,
    input  tmds, disparity
  );
  modport slave (
    input  video_data, data_island_data,
    input  control_data, mode,
    output tmds, disparity
  );
`else
  modport master (
    output video_data, data_island_data,
    output control_data, mode,
    input  tmds
  );
  modport slave (
    input  video_data, data_island_data,
    input  control_data, mode,
    output tmds
  );
`endif
endinterface

// File: rtl/tmds_channel_rd.sv
// HDMI TMDS lane encoder: video 8b/10b with running disparity, TERC4,
// control and guard bands, all through a fixed 2-register pipeline.
// Ports: i_clk_pixel, i_reset (sync, active-high), bus (slave modport:
// video_data, data_island_data, control_data, mode in; tmds out).
// Optional TMDS_DISP_MON_EN adds bus.disparity (running cnt monitor).
module tmds_channel_rd #(
  parameter int CN = 0
) (
  input  logic i_clk_pixel,
  input  logic i_reset,
  tmds_channel_rd_if.slave bus
);

  localparam logic [9:0] CTRL00 = 10'b1101010100;
  localparam logic [9:0] GB_A   = 10'b1011001100;
  localparam logic [9:0] GB_B   = 10'b0100110011;
  localparam logic [9:0] VGB =
    (CN == 0 || CN == 2) ? GB_A :
    (CN == 1)            ? GB_B : 10'd0;

  function automatic logic [9:0] terc4(input logic [3:0] n);
    logic [9:0] s;
    unique case (n)
      4'h0: s = 10'b1010011100;
      4'h1: s = 10'b1001100011;
      4'h2: s = 10'b1011100100;
      4'h3: s = 10'b1011100010;
      4'h4: s = 10'b0101110001;
      4'h5: s = 10'b0100011110;
      4'h6: s = 10'b0110001110;
      4'h7: s = 10'b0100111100;
      4'h8: s = 10'b1011001100;
      4'h9: s = 10'b0100111001;
      4'hA: s = 10'b0110011100;
      4'hB: s = 10'b1011000110;
      4'hC: s = 10'b1010001110;
      4'hD: s = 10'b1001110001;
      4'hE: s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  // Stage 1: transition-minimised q_m
  logic [3:0] w_n1d;
  logic       w_xnor;
  logic [8:0] w_qm;

  always_comb begin
    w_n1d = '0;
    for (int k = 0; k < 8; k++)
      w_n1d = w_n1d + {3'b0, bus.video_data[k]};
    w_xnor = (w_n1d > 4'd4) ||
             (w_n1d == 4'd4 && !bus.video_data[0]);
    w_qm = '0;
    w_qm[0] = bus.video_data[0];
    for (int k = 1; k < 8; k++)
      w_qm[k] = w_xnor ^ w_qm[k-1] ^ bus.video_data[k];
    w_qm[8] = ~w_xnor;
  end

  logic [8:0] r_qm;
  logic [2:0] r_mode;
  logic [1:0] r_ctrl;
  logic [3:0] r_nib;

  always_ff @(posedge i_clk_pixel) begin
    if (i_reset) begin
      r_qm   <= '0;
      r_mode <= '0;
      r_ctrl <= '0;
      r_nib  <= '0;
    end else begin
      r_qm   <= w_qm;
      r_mode <= bus.mode;
      r_ctrl <= bus.control_data;
      r_nib  <= bus.data_island_data;
    end
  end

  // Stage 2: DC balancing and mode select
  logic        [3:0] w_n1;
  logic        [3:0] w_n0;
  logic signed [5:0] w_diff;
  logic signed [5:0] w_two_q8;
  logic signed [5:0] w_two_nq8;
  logic              w_q8;
  logic        [7:0] w_q;
  logic        [9:0] w_tmds;
  logic signed [5:0] w_cnt;
  logic signed [5:0] r_cnt;
  logic        [9:0] r_tmds;
  logic              w_pos;
  logic              w_neg;

  always_comb begin
    w_n1 = '0;
    for (int k = 0; k < 8; k++)
      w_n1 = w_n1 + {3'b0, r_qm[k]};
    w_n0      = 4'd8 - w_n1;
    w_diff    = $signed({2'b00, w_n1}) - $signed({2'b00, w_n0});
    w_q8      = r_qm[8];
    w_q       = r_qm[7:0];
    w_two_q8  = $signed({4'b0, w_q8, 1'b0});
    w_two_nq8 = $signed({4'b0, ~w_q8, 1'b0});
    w_pos     = !r_cnt[5] && (r_cnt != 6'sd0);
    w_neg     = r_cnt[5];
    w_tmds    = 10'd0;
    w_cnt     = 6'sd0;
    unique case (r_mode)
      3'd0: w_tmds = (r_ctrl == 2'b00) ? CTRL00 :
                     (r_ctrl == 2'b01) ? 10'b0010101011 :
                     (r_ctrl == 2'b10) ? 10'b0101010100 :
                                         10'b1010101011;
      3'd1: begin
        if (r_cnt == 6'sd0 || w_n1 == w_n0) begin
          w_tmds = {~w_q8, w_q8, w_q8 ? w_q : ~w_q};
          w_cnt  = w_q8 ? r_cnt + w_diff : r_cnt - w_diff;
        end else if ((w_pos && w_n1 > w_n0) ||
                     (w_neg && w_n0 > w_n1)) begin
          w_tmds = {1'b1, w_q8, ~w_q};
          w_cnt  = r_cnt + w_two_q8 - w_diff;
        end else begin
          w_tmds = {1'b0, w_q8, w_q};
          w_cnt  = r_cnt + w_diff - w_two_nq8;
        end
      end
      3'd2: w_tmds = VGB;
      3'd3: w_tmds = terc4(r_nib);
      3'd4: w_tmds = (CN == 0) ? terc4({2'b11, r_ctrl}) :
                     (CN == 1 || CN == 2) ? GB_B : 10'd0;
      default: w_tmds = 10'd0;
    endcase
  end

  always_ff @(posedge i_clk_pixel) begin
    if (i_reset) begin
      r_tmds <= CTRL00;
      r_cnt  <= 6'sd0;
    end else begin
      r_tmds <= w_tmds;
      r_cnt  <= w_cnt;
    end
  end

  assign bus.tmds = r_tmds;
`ifdef TMDS_DISP_MON_EN
  assign bus.disparity = r_cnt;
`endif

endmodule
